// File: rtl/mem_port_if.sv
// Request/response bundle between the microcode sequencer (master) and the
// memory port controller (slave).
interface mem_port_if;
  logic        i_or_d;
  logic [31:0] pc;
  logic [31:0] alu_out;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] write_data;
  logic [31:0] dout;
  logic        ready;
  logic        busy;
  logic        mem_err;

  modport master (
    output i_or_d, pc, alu_out, mem_read, mem_write, write_data,
    input  dout, ready, busy, mem_err
  );

  modport slave (
    input  i_or_d, pc, alu_out, mem_read, mem_write, write_data,
    output dout, ready, busy, mem_err
  );
endinterface

// File: rtl/mem_port_ctrl.sv
// Fixed-latency single-port word memory with an IDLE/BUSY/DONE handshake.
// Optional misaligned-access suppression is enabled by MEM_MISALIGN_CHECK_EN.
module mem_port_ctrl #(
  parameter int LATENCY     = 2,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic      clk,
  input  logic      reset,
  mem_port_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic        op_write_r;
  logic [31:0] dout_r;
  logic        ready_r;
  logic        busy_r;
  logic        mem_err_r;

  logic [31:0] mem_r [DEPTH_WORDS];

  logic [31:0]   sel_addr_s;
  logic [AW-1:0] idx_s;
  logic          misalign_s;
  logic          complete_s;
  logic          do_access_s;
  logic          mem_we_s;
  logic          unused_addr_s;

  // Address mux and completion qualifiers derived from latched request
  always_comb begin
    sel_addr_s = 32'h0000_0000;
    if (bus.i_or_d) begin
      sel_addr_s = bus.alu_out;
    end else begin
      sel_addr_s = bus.pc;
    end
    idx_s = addr_r[AW+1:2];
`ifdef MEM_MISALIGN_CHECK_EN
    misalign_s = (addr_r[1:0] != 2'b00);
`else
    misalign_s = 1'b0;
`endif
    complete_s  = (state_r == BUSY) && (cnt_r == 4'd0);
    do_access_s = complete_s && !misalign_s;
    // reset low at the completing edge aborts the write
    mem_we_s    = do_access_s && op_write_r && reset;
  end

  // Upper address bits wrap modulo the array size
  assign unused_addr_s = ^{addr_r[31:AW+2], addr_r[1:0]};

  // Request FSM with registered handshake outputs and read data
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      addr_r     <= 32'h0000_0000;
      wdata_r    <= 32'h0000_0000;
      op_write_r <= 1'b0;
      dout_r     <= 32'h0000_0000;
      ready_r    <= 1'b0;
      busy_r     <= 1'b0;
      mem_err_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ready_r   <= 1'b0;
          mem_err_r <= 1'b0;
          if (bus.mem_read || bus.mem_write) begin
            state_r    <= BUSY;
            cnt_r      <= 4'(LATENCY - 1);
            addr_r     <= sel_addr_s;
            wdata_r    <= bus.write_data;
            op_write_r <= bus.mem_write;
            busy_r     <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        BUSY: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            state_r   <= DONE;
            ready_r   <= 1'b1;
            mem_err_r <= misalign_s;
            if (do_access_s && !op_write_r) begin
              dout_r <= mem_r[idx_s];
            end else begin
              dout_r <= dout_r;
            end
          end
        end
        DONE: begin
          state_r   <= IDLE;
          ready_r   <= 1'b0;
          mem_err_r <= 1'b0;
          busy_r    <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          cnt_r     <= 4'd0;
          ready_r   <= 1'b0;
          mem_err_r <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  // Storage array; intentionally not cleared by reset
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[idx_s] <= wdata_r;
    end
  end

  assign bus.dout    = dout_r;
  assign bus.ready   = ready_r;
  assign bus.busy    = busy_r;
  assign bus.mem_err = mem_err_r;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed scoreboard bench for mem_port_ctrl (LATENCY=2, 1024 words).
// Expectations follow MEM_MISALIGN_CHECK_EN when that macro is defined.
module tb_mem_port_ctrl;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  mem_port_if bus ();

  mem_port_ctrl #(.LATENCY(LAT), .DEPTH_WORDS(1024)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dout;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model[int];
  logic [31:0] dout_m;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete request: drive, push expectation, wait for ready, pop and compare
  task automatic req(input logic rd, input logic wr, input logic sel,
                     input logic [31:0] pcv, input logic [31:0] alu,
                     input logic [31:0] wd, input string tag);
    logic [31:0] a;
    int          idx;
    int          n;
    logic        misal;
    exp_t        e;
    a   = sel ? alu : pcv;
    idx = int'(a[11:2]);
`ifdef MEM_MISALIGN_CHECK_EN
    misal = (a[1:0] != 2'b00);
`else
    misal = 1'b0;
`endif
    if (wr) begin
      if (!misal) model[idx] = wd;
    end else begin
      if (!misal) dout_m = model[idx];
    end
    e.dout = dout_m;
    e.err  = misal;
    sb.push_back(e);
    bus.mem_read = rd; bus.mem_write = wr; bus.i_or_d = sel;
    bus.pc = pcv; bus.alu_out = alu; bus.write_data = wd;
    @(posedge clk); #1;
    // scramble inputs after acceptance; latched values must govern
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.write_data = ~wd;
    bus.pc = pcv + 32'h0000_0104; bus.alu_out = alu + 32'h0000_0104;
    n = 0;
    while (bus.ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check32({tag, "_latency"}, n, LAT);
    e = sb.pop_front();
    check32({tag, "_dout"}, bus.dout, e.dout);
    check32({tag, "_err"}, {31'd0, bus.mem_err}, {31'd0, e.err});
    check32({tag, "_busy_done"}, {31'd0, bus.busy}, 32'd1);
    @(posedge clk); #1;
    check32({tag, "_idle"}, {30'd0, bus.busy, bus.ready}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.i_or_d = 1'b0;
    bus.pc = 32'h0; bus.alu_out = 32'h0; bus.write_data = 32'h0;
    dout_m = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check32("rst_outs", {29'd0, bus.ready, bus.busy, bus.mem_err}, 32'd0);
    check32("rst_dout", bus.dout, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    // write then read back via alu_out
    req(1'b0, 1'b1, 1'b1, 32'h0, 32'h40, 32'hDEAD_BEEF, "wr40");
    req(1'b1, 1'b0, 1'b1, 32'h0, 32'h40, 32'h0, "rd40");

    // pc selects word 2, not word 16
    req(1'b0, 1'b1, 1'b1, 32'h0, 32'h08, 32'h2222_2222, "wr08");
    req(1'b1, 1'b0, 1'b0, 32'h08, 32'h40, 32'h0, "rd_pc08");

    // both strobes: write wins, dout unchanged
    req(1'b1, 1'b1, 1'b1, 32'h0, 32'h10, 32'h0000_1234, "both10");
    req(1'b1, 1'b0, 1'b1, 32'h0, 32'h10, 32'h0, "rd10");

    // reset one edge after accepting a write aborts it
    req(1'b0, 1'b1, 1'b1, 32'h0, 32'h20, 32'hA5A5_A5A5, "wr20");
    bus.mem_write = 1'b1; bus.i_or_d = 1'b1; bus.alu_out = 32'h20; bus.write_data = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    bus.mem_write = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    check32("abort_busy", {31'd0, bus.busy}, 32'd0);
    check32("abort_ready", {31'd0, bus.ready}, 32'd0);
    check32("abort_dout", bus.dout, 32'h0);
    dout_m = 32'h0;
    sb.delete();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check32("abort_no_ready", {31'd0, bus.ready}, 32'd0);
    end
    req(1'b1, 1'b0, 1'b1, 32'h0, 32'h20, 32'h0, "rd20_after_abort");

    // misaligned read of 0x42
    req(1'b1, 1'b0, 1'b1, 32'h0, 32'h42, 32'h0, "rd42");

    // upper address bits wrap onto word 16
    req(1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_1040, 32'hCAFE_F00D, "wr1040");
    req(1'b1, 1'b0, 1'b1, 32'h0, 32'h40, 32'h0, "rd40_wrap");

    // strobe held through BUSY with a moving address
    req(1'b0, 1'b1, 1'b1, 32'h0, 32'h44, 32'h4444_4444, "wr44");
    req(1'b0, 1'b1, 1'b1, 32'h0, 32'h48, 32'h4848_4848, "wr48");
    bus.mem_read = 1'b1; bus.i_or_d = 1'b1; bus.alu_out = 32'h40;
    @(posedge clk); #1;
    check32("hold_busy0", {31'd0, bus.busy}, 32'd1);
    bus.alu_out = 32'h44;
    @(posedge clk); #1;
    bus.alu_out = 32'h48;
    @(posedge clk); #1;
    check32("hold_ready1", {31'd0, bus.ready}, 32'd1);
    check32("hold_dout1", bus.dout, 32'hCAFE_F00D);
    @(posedge clk); #1;
    check32("hold_idle", {30'd0, bus.busy, bus.ready}, 32'd0);
    @(posedge clk); #1;
    check32("hold_reaccept", {31'd0, bus.busy}, 32'd1);
    bus.alu_out = 32'h44;
    @(posedge clk); #1;
    check32("hold_no_early_ready", {31'd0, bus.ready}, 32'd0);
    @(posedge clk); #1;
    bus.mem_read = 1'b0;
    check32("hold_ready2", {31'd0, bus.ready}, 32'd1);
    check32("hold_dout2", bus.dout, 32'h4848_4848);
    @(posedge clk); #1;
    check32("hold_end_idle", {30'd0, bus.busy, bus.ready}, 32'd0);
    dout_m = 32'h4848_4848;

    req(1'b1, 1'b0, 1'b1, 32'h0, 32'h44, 32'h0, "rd44");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_ctrl.md
MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

Interface
REQ-001 Parameter LATENCY, default 2: rising edges from request acceptance to completion; legal range 1..15.
REQ-002 Parameter DEPTH_WORDS, default 1024: number of 32-bit words in the internal array; power of two.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-low reset.
REQ-005 Port i_or_d, input, 1: address select; 0 selects pc, 1 selects alu_out.
REQ-006 Port pc, input, 32: instruction-fetch byte address.
REQ-007 Port alu_out, input, 32: data byte address.
REQ-008 Port mem_read, input, 1: read request strobe from the microcode sequencer.
REQ-009 Port mem_write, input, 1: write request strobe from the microcode sequencer.
REQ-010 Port write_data, input, 32: store data.
REQ-011 Port dout, output, 32: last completed read word; consumed by the IR/MDR latches.
REQ-012 Port ready, output, 1: one-cycle completion pulse; the sequencer advances past IF/MEM states on it.
REQ-013 Port busy, output, 1: high while a request is in flight (BUSY or DONE).
REQ-014 Port mem_err, output, 1: misaligned-access flag; valid only while ready=1.

Function
REQ-015 FSM states: IDLE, BUSY, DONE.
REQ-016 IDLE, mem_read|mem_write sampled high -> BUSY, cnt=LATENCY-1; latch addr (per i_or_d), write_data, op.
REQ-017 Both strobes high at acceptance -> op=write; the read is dropped.
REQ-018 BUSY: cnt!=0 -> cnt-1; cnt==0 -> DONE and perform the latched access at that edge.
REQ-019 DONE lasts exactly one cycle, ready=1, then -> IDLE unconditionally; a new request can be accepted no earlier than the first IDLE cycle.
REQ-020 Latency: request accepted at edge E0 -> ready high in the cycle after edge E(LATENCY).
REQ-021 Strobes and data inputs are ignored in BUSY/DONE; latched values govern the access.
REQ-022 Word index = addr[log2(DEPTH_WORDS)+1:2]; upper bits are ignored (modulo wrap).
REQ-023 A read updates dout at the completing edge; dout holds its value otherwise, and writes never alter dout.
REQ-024 A write updates the array at the completing edge; a read of the same word at a later request returns the new data.
REQ-025 busy = (state != IDLE).

Reset
REQ-026 reset=0 at an edge: state=IDLE, cnt=0, ready=0, busy=0, mem_err=0, dout=0.
REQ-027 Reset mid-operation aborts the access: no array write occurs, no ready pulse is produced.
REQ-028 Array contents are not cleared by reset.

Configuration
REQ-029 Macro MEM_MISALIGN_CHECK_EN defined: latched addr[1:0]!=0 -> access suppressed (no array write, dout unchanged), ready still pulses with mem_err=1.
REQ-030 Macro MEM_MISALIGN_CHECK_EN undefined: addr[1:0] is ignored, the access proceeds normally, and mem_err is tied to 0.

Verification
REQ-031 LATENCY=2; write 0xDEADBEEF to alu_out=0x40 (i_or_d=1), then read 0x40 -> ready 2 edges after each acceptance, dout=0xDEADBEEF.
REQ-032 i_or_d=0, pc=0x8, alu_out=0x40, read -> dout=word[2], not word[16].
REQ-033 mem_read=mem_write=1 with data 0x1234 at 0x10 -> write performed; dout unchanged; a later read of 0x10 returns 0x1234.
REQ-034 reset=0 one edge after accepting a write to 0x20 -> no ready pulse, busy=0 next cycle, word at 0x20 unchanged.
REQ-035 MEM_MISALIGN_CHECK_EN defined, read 0x42 -> ready=1 with mem_err=1, dout unchanged; macro undefined -> dout=word[16], mem_err=0.
REQ-036 Strobe held high through BUSY with changing alu_out -> exactly one access at the latched address; next acceptance occurs in the first IDLE cycle after DONE.
